ex_mem_skid: RTL and testbench

// - EX->MEM pipeline boundary of the MIPS core: registers the EX arithmetic result with valid/ready flow control.
// - A 2-entry skid buffer makes ex_ready a pure register output, so MEM backpressure never reaches EX combinationally.
// - Converts the EX add/sub overflow flags into the precise Ov exception; the faulting instruction's register write is squashed.

---
 rtl/ex_mem_skid.sv | 198 +++++++++++++++++++
 tb/tb_ex_mem_skid.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_skid.sv
// ex_mem_skid -- EX->MEM pipeline boundary of the MIPS core.
//
// This module registers the EX result and passes it to MEM with valid/ready flow control.
// A two-entry skid buffer (main + skid) drives ex_ready straight from a flop, so
// backpressure from MEM never reaches EX through combinational logic.
// An add/sub overflow signalled by EX becomes a precise Ov exception on the entry.
// When that happens, the entry's register write is squashed.
//
// Optional feature: define EX_MEM_PERF_EN to build the stall and overflow
// performance counters. Without it both counter ports are tied to zero.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   flush             drops both entries and any same-cycle input
//   ex_valid/ex_ready EX-side handshake (ex_ready is a flop output)
//   ex_pc, ex_alu_op, ex_result, ex_add_ovf, ex_sub_ovf, ex_wd, ex_wreg, ex_in_dslot
//                     EX instruction payload
//   mem_valid/mem_ready MEM-side handshake
//   mem_pc, mem_result, mem_wd, mem_wreg, mem_exc, mem_excode, mem_in_dslot
//                     head-entry payload
//   perf_stall_cnt    cycles with mem_valid && !mem_ready
//   perf_ovf_cnt      accepted overflow instructions
//   dbg_state         current FSM state (0 EMPTY, 1 ONE, 2 TWO)
//
// Handshake: a beat moves when valid && ready are both high at a rising edge.
//   The producer holds its payload stable while valid && !ready.
//   valid never depends combinationally on ready on the same side.

module ex_mem_skid #(
  parameter logic [4:0] OV_EXCODE = 5'h0C,
  parameter int         PC_W      = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [PC_W-1:0] ex_pc,
  input  logic [7:0]      ex_alu_op,
  input  logic [31:0]     ex_result,
  input  logic            ex_add_ovf,
  input  logic            ex_sub_ovf,
  input  logic [4:0]      ex_wd,
  input  logic            ex_wreg,
  input  logic            ex_in_dslot,
  output logic            mem_valid,
  input  logic            mem_ready,
  output logic [PC_W-1:0] mem_pc,
  output logic [31:0]     mem_result,
  output logic [4:0]      mem_wd,
  output logic            mem_wreg,
  output logic            mem_exc,
  output logic [4:0]      mem_excode,
  output logic            mem_in_dslot,
  output logic [31:0]     perf_stall_cnt,
  output logic [31:0]     perf_ovf_cnt,
  output logic [1:0]      dbg_state
);

  // ALU op codes that can trap (defines.v encodings).
  localparam logic [7:0] EXE_ADD_OP = 8'b0010_0000;
  localparam logic [7:0] EXE_SUB_OP = 8'b0010_0010;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     result;
    logic [4:0]      wd;
    logic            wreg;
    logic            exc;
    logic [4:0]      excode;
    logic            in_dslot;
  } entry_t;

  state_t state_q, state_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic   ex_ready_q, ex_ready_d;

  logic   in_xfer;
  logic   out_xfer;
  logic   ovf;
  entry_t new_entry;

  always_comb begin
    in_xfer  = ex_valid && ex_ready_q;
    out_xfer = (state_q != S_EMPTY) && mem_ready;

    // Only the trapping ADD/SUB forms raise Ov; ADDU/SUBU/SLT/SLTU ignore the flags.
    ovf = ((ex_alu_op == EXE_ADD_OP) && ex_add_ovf) ||
          ((ex_alu_op == EXE_SUB_OP) && ex_sub_ovf);

    new_entry.pc       = ex_pc;
    new_entry.result   = ex_result;
    new_entry.wd       = ex_wd;
    new_entry.wreg     = ex_wreg && !ovf;
    new_entry.exc      = ovf;
    new_entry.excode   = ovf ? OV_EXCODE : 5'h00;
    new_entry.in_dslot = ex_in_dslot;

    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (in_xfer) begin
            state_d = S_ONE;
            main_d  = new_entry;
          end
        end
        S_ONE: begin
          if (in_xfer && !out_xfer) begin
            state_d = S_TWO;
            skid_d  = new_entry;
          end else if (in_xfer && out_xfer) begin
            main_d  = new_entry;
          end else if (out_xfer) begin
            state_d = S_EMPTY;
          end
        end
        S_TWO: begin
          // ex_ready_q is 0 here, so no input can arrive; only drain.
          if (out_xfer) begin
            state_d = S_ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end

    // Registered ready: computed from the next state so it is valid the cycle it is seen.
    ex_ready_d = (state_d != S_TWO);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_EMPTY;
      ex_ready_q <= 1'b1;
      main_q     <= '0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      ex_ready_q <= ex_ready_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
    end
  end

  assign ex_ready     = ex_ready_q;
  assign mem_valid    = (state_q != S_EMPTY);
  assign mem_pc       = main_q.pc;
  assign mem_result   = main_q.result;
  assign mem_wd       = main_q.wd;
  // Stale payload after a flush must never look like a write or an exception.
  assign mem_wreg     = main_q.wreg && mem_valid;
  assign mem_exc      = main_q.exc && mem_valid;
  assign mem_excode   = main_q.excode;
  assign mem_in_dslot = main_q.in_dslot;
  assign dbg_state    = state_q;

`ifdef EX_MEM_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] ovf_cnt_q, ovf_cnt_d;

  // Counters survive flush; only rst clears them. Both wrap naturally at 2^32.
  always_comb begin
    stall_cnt_d = stall_cnt_q + ((mem_valid && !mem_ready) ? 32'd1 : 32'd0);
    ovf_cnt_d   = ovf_cnt_q + ((in_xfer && ovf && !flush) ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 32'd0;
      ovf_cnt_q   <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      ovf_cnt_q   <= ovf_cnt_d;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_ovf_cnt   = ovf_cnt_q;
`else
  assign perf_stall_cnt = 32'h0;
  assign perf_ovf_cnt   = 32'h0;
`endif

endmodule

// File: tb/tb_ex_mem_skid.sv
// tb_ex_mem_skid -- bench for ex_mem_skid.
// Reference: the boundary behaves as a 2-deep FIFO of packed entries (exp_q).
// ex_ready is high whenever fewer than two entries are held after the edge.
// flush empties the FIFO; rst also clears the perf counters.
// Directed cases come first, then randomized traffic with occasional flush/rst.

module tb_ex_mem_skid;

  localparam logic [7:0] OP_ADD  = 8'b0010_0000;
  localparam logic [7:0] OP_ADDU = 8'b0010_0001;
  localparam logic [7:0] OP_SUB  = 8'b0010_0010;
  localparam logic [7:0] OP_SUBU = 8'b0010_0011;
  localparam logic [7:0] OP_SLT  = 8'b0010_1010;
  localparam logic [7:0] OP_SLTU = 8'b0010_1011;
  localparam int EW = 77;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst, flush;
  logic        ex_valid, ex_ready;
  logic [31:0] ex_pc;
  logic [7:0]  ex_alu_op;
  logic [31:0] ex_result;
  logic        ex_add_ovf, ex_sub_ovf;
  logic [4:0]  ex_wd;
  logic        ex_wreg, ex_in_dslot;
  logic        mem_valid, mem_ready;
  logic [31:0] mem_pc, mem_result;
  logic [4:0]  mem_wd;
  logic        mem_wreg, mem_exc;
  logic [4:0]  mem_excode;
  logic        mem_in_dslot;
  logic [31:0] perf_stall_cnt, perf_ovf_cnt;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  ex_mem_skid #(.OV_EXCODE(5'h0C), .PC_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc), .ex_alu_op(ex_alu_op),
    .ex_result(ex_result), .ex_add_ovf(ex_add_ovf), .ex_sub_ovf(ex_sub_ovf),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_in_dslot(ex_in_dslot),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_pc(mem_pc),
    .mem_result(mem_result), .mem_wd(mem_wd), .mem_wreg(mem_wreg),
    .mem_exc(mem_exc), .mem_excode(mem_excode), .mem_in_dslot(mem_in_dslot),
    .perf_stall_cnt(perf_stall_cnt), .perf_ovf_cnt(perf_ovf_cnt),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  bit            m_ready;
  logic [31:0]   m_stall, m_ovf;
  int            n_checks = 0;
  int            n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Entry layout: {pc, result, wd, wreg, exc, excode, in_dslot}
  function automatic logic [EW-1:0] expect_entry();
    bit trap;
    trap = (ex_alu_op == OP_ADD && ex_add_ovf) || (ex_alu_op == OP_SUB && ex_sub_ovf);
    return {ex_pc, ex_result, ex_wd, trap ? 1'b0 : ex_wreg, trap,
            trap ? 5'h0C : 5'h00, ex_in_dslot};
  endfunction

  task automatic model_update();
    bit acc;
    if (rst) begin
      exp_q.delete();
      m_ready = 1'b1;
      m_stall = 32'd0;
      m_ovf   = 32'd0;
    end else begin
      if (exp_q.size() > 0 && !mem_ready) m_stall = m_stall + 32'd1;
      if (flush) begin
        exp_q.delete();
        m_ready = 1'b1;
      end else begin
        acc = ex_valid && m_ready;
        if (exp_q.size() > 0 && mem_ready) void'(exp_q.pop_front());
        if (acc) begin
          logic [EW-1:0] e;
          e = expect_entry();
          if (e[6]) m_ovf = m_ovf + 32'd1;
          exp_q.push_back(e);
        end
        m_ready = (exp_q.size() < 2);
      end
    end
  endtask

  task automatic check_outputs();
    logic [EW-1:0] e;
    check("mem_valid", {31'd0, mem_valid}, {31'd0, exp_q.size() != 0});
    check("ex_ready", {31'd0, ex_ready}, {31'd0, m_ready});
    if (exp_q.size() > 0) begin
      e = exp_q[0];
      check("mem_pc", mem_pc, e[76:45]);
      check("mem_result", mem_result, e[44:13]);
      check("mem_wd", {27'd0, mem_wd}, {27'd0, e[12:8]});
      check("mem_wreg", {31'd0, mem_wreg}, {31'd0, e[7]});
      check("mem_exc", {31'd0, mem_exc}, {31'd0, e[6]});
      check("mem_excode", {27'd0, mem_excode}, {27'd0, e[5:1]});
      check("mem_in_dslot", {31'd0, mem_in_dslot}, {31'd0, e[0]});
    end else begin
      check("idle_wreg", {31'd0, mem_wreg}, 32'd0);
      check("idle_exc", {31'd0, mem_exc}, 32'd0);
    end
`ifdef EX_MEM_PERF_EN
    check("perf_stall", perf_stall_cnt, m_stall);
    check("perf_ovf", perf_ovf_cnt, m_ovf);
`else
    check("perf_stall_off", perf_stall_cnt, 32'd0);
    check("perf_ovf_off", perf_ovf_cnt, 32'd0);
`endif
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_instr(input bit v, input logic [7:0] op, input logic [31:0] pc,
                           input logic [31:0] res, input bit aovf, input bit sovf,
                           input logic [4:0] wd, input bit wreg, input bit dslot);
    ex_valid = v; ex_alu_op = op; ex_pc = pc; ex_result = res;
    ex_add_ovf = aovf; ex_sub_ovf = sovf; ex_wd = wd; ex_wreg = wreg; ex_in_dslot = dslot;
  endtask

  // One clock: drive control, update the model at the edge, check at the falling edge.
  task automatic cycle(input bit mr, input bit fl, input bit r);
    mem_ready = mr; flush = fl; rst = r;
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle();
    set_instr(0, OP_ADDU, 32'd0, 32'd0, 0, 0, 5'd0, 0, 0);
  endtask

  // ---------------- stimulus ----------------
  localparam logic [7:0] OPS [6] = '{OP_ADD, OP_ADDU, OP_SUB, OP_SUBU, OP_SLT, OP_SLTU};

  initial begin
    m_ready = 1'b1; m_stall = 32'd0; m_ovf = 32'd0;
    idle();
    mem_ready = 1'b0; flush = 1'b0; rst = 1'b1;
    @(negedge clk);
    cycle(0, 0, 1);
    cycle(0, 0, 1);

    // Reset state
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    check("rst_pc", mem_pc, 32'd0);
    check("rst_result", mem_result, 32'd0);
    check("rst_wd", {27'd0, mem_wd}, 32'd0);
    check("rst_excode", {27'd0, mem_excode}, 32'd0);
    check("rst_dslot", {31'd0, mem_in_dslot}, 32'd0);

    // Back-to-back ADDU 1+2, 3+4
    set_instr(1, OP_ADDU, 32'h100, 32'd3, 0, 0, 5'd2, 1, 0);
    cycle(1, 0, 0);
    check("b2b_first", mem_result, 32'd3);
    check("b2b_rdy1", {31'd0, ex_ready}, 32'd1);
    set_instr(1, OP_ADDU, 32'h104, 32'd7, 0, 0, 5'd3, 1, 0);
    cycle(1, 0, 0);
    check("b2b_second", mem_result, 32'd7);
    check("b2b_rdy2", {31'd0, ex_ready}, 32'd1);

    // ADD overflow traps
    set_instr(1, OP_ADD, 32'h108, 32'h8000_0000, 1, 0, 5'd4, 1, 1);
    cycle(1, 0, 0);
    check("add_ov_exc", {31'd0, mem_exc}, 32'd1);
    check("add_ov_code", {27'd0, mem_excode}, 32'h0C);
    check("add_ov_wreg", {31'd0, mem_wreg}, 32'd0);
    check("add_ov_res", mem_result, 32'h8000_0000);

    // SUBU never traps
    set_instr(1, OP_SUBU, 32'h10C, 32'hDEAD_BEEF, 0, 1, 5'd5, 1, 0);
    cycle(1, 0, 0);
    check("subu_exc", {31'd0, mem_exc}, 32'd0);
    check("subu_wreg", {31'd0, mem_wreg}, 32'd1);
    check("subu_res", mem_result, 32'hDEAD_BEEF);
    idle();
    cycle(1, 0, 0);

    // Backpressure: three issued, two held, third waits
    set_instr(1, OP_ADDU, 32'h200, 32'hA1, 0, 0, 5'd1, 1, 0);
    cycle(0, 0, 0);
    set_instr(1, OP_ADDU, 32'h204, 32'hA2, 0, 0, 5'd1, 1, 0);
    cycle(0, 0, 0);
    check("bp_full_rdy", {31'd0, ex_ready}, 32'd0);
    set_instr(1, OP_ADDU, 32'h208, 32'hA3, 0, 0, 5'd1, 1, 0);
    cycle(0, 0, 0);
    check("bp_head_a", mem_result, 32'hA1);
    cycle(1, 0, 0);
    check("bp_head_b", mem_result, 32'hA2);
    cycle(1, 0, 0);
    check("bp_head_c", mem_result, 32'hA3);
    idle();
    cycle(1, 0, 0);
    check("bp_drained", {31'd0, mem_valid}, 32'd0);

    // Flush from TWO with a same-cycle input
    set_instr(1, OP_ADDU, 32'h300, 32'hB1, 0, 0, 5'd6, 1, 0);
    cycle(0, 0, 0);
    set_instr(1, OP_ADDU, 32'h304, 32'hB2, 0, 0, 5'd6, 1, 0);
    cycle(0, 0, 0);
    set_instr(1, OP_ADDU, 32'h308, 32'hB3, 0, 0, 5'd6, 1, 0);
    cycle(0, 1, 0);
    check("fl_valid", {31'd0, mem_valid}, 32'd0);
    check("fl_ready", {31'd0, ex_ready}, 32'd1);
    idle();
    cycle(1, 0, 0);
    check("fl_nothing", {31'd0, mem_valid}, 32'd0);

    // Perf counters: 5 stall cycles, 2 overflow accepts, then rst
    cycle(1, 0, 1);
    set_instr(1, OP_ADD, 32'h400, 32'h7FFF_FFFF, 1, 0, 5'd7, 1, 0);
    cycle(1, 0, 0);
    set_instr(1, OP_SUB, 32'h404, 32'h8000_0001, 0, 1, 5'd7, 1, 0);
    cycle(0, 0, 0);
    idle();
    for (int i = 0; i < 4; i++) cycle(0, 0, 0);
`ifdef EX_MEM_PERF_EN
    check("perf_stall5", perf_stall_cnt, 32'd5);
    check("perf_ovf2", perf_ovf_cnt, 32'd2);
`endif
    cycle(0, 0, 1);
    check("perf_rst_stall", perf_stall_cnt, 32'd0);
    check("perf_rst_ovf", perf_ovf_cnt, 32'd0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      set_instr($urandom_range(0, 3) != 0, OPS[$urandom_range(0, 5)], $urandom, $urandom,
                $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                5'($urandom_range(0, 31)), $urandom_range(0, 1) == 1,
                $urandom_range(0, 1) == 1);
      cycle($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, $urandom_range(0, 199) == 0);
    end

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
